maxpool_l1: RTL
===============

Name: maxpool_l1

Overview:
- Layer-1 stage that runs directly downstream of the layer-0 convolution/ReLU engine.
- After layer 0 has filled L0 memory (64x64, 20-bit, 4.16 signed fixed point), this block performs 2x2 stride-2 max pooling.
- Writes the 32x32 result into L1 memory over the shared csel-multiplexed memory bus.
- Started by a one-cycle start pulse from the top-level controller; reports busy and a done pulse.

Parameters:
- IMG_W, 64, input image width/height in pixels.
- DW, 20, data width of L0/L1 words (signed 4.16).
- AW, 12, memory address width.
- RD_LAT, 1, cycles from a read request edge to the edge where cdata_rd is sampled (1..3).
- SEL_L0, 3'b001, csel code for L0 memory.
- SEL_L1, 3'b011, csel code for L1 memory.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins pooling when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last L1 write.
- crd  out  1  memory read strobe.
- caddr_rd  out  AW  L0 read address.
- cdata_rd  in  DW  L0 read data.
- cwr  out  1  memory write strobe.
- caddr_wr  out  AW  L1 write address.
- cdata_wr  out  DW  L1 write data.
- csel  out  3  memory select.

Behaviour:
- All outputs are registered.
- Reset values (reset low, asynchronous): busy=0, done=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, csel=3'b000; state=IDLE; output index o=0.
- Output index o runs 0..1023. ox=o[4:0], oy=o[9:5]. Base address b = (2*oy)*IMG_W + 2*ox.
- Window read order per output: b, b+1, b+IMG_W, b+IMG_W+1.
- IDLE: outputs quiescent (crd=cwr=0, csel=000). When start=1 is sampled, go to READ and set busy=1.
- READ (4 cycles): crd=1, csel=SEL_L0, caddr_rd steps through the four window addresses, one per cycle.
  - Read k returns on cdata_rd at the edge RD_LAT cycles after the edge that presented it.
  - Returned samples update a signed DW-bit running max.
  - The first sample of each window loads the max register unconditionally; it is never compared with 0, so all-negative windows pool correctly.
  - Comparison is signed two's complement.
- DRAIN (RD_LAT cycles): crd=0, csel holds SEL_L0, remaining samples are absorbed.
- WRITE (1 cycle): cwr=1, csel=SEL_L1, caddr_wr = zero-extended o, cdata_wr = max.
  - If o==1023, go to FIN.
  - Otherwise increment o and go to READ.
- FIN (1 cycle): done=1, busy=0, cwr=0, csel=000, o cleared to 0. Then go to IDLE.
- Per-output cost is 5+RD_LAT cycles; a full frame is 1024*(5+RD_LAT) cycles from the first READ to the last WRITE.
- Invariants:
  - crd and cwr are never high in the same cycle.
  - csel never changes value while crd=1.
  - cwr is a single-cycle pulse.
- start while busy=1 is ignored (no restart, no queue).
- start on the FIN cycle is ignored; start is honoured again from IDLE.
- Reset mid-frame aborts immediately to reset values. L1 contents already written are left as-is; no partial write is issued.
- No saturation or rounding; the output is bit-exact equal to one of the four inputs.

Decomposition:
- Shared package maxpool_pkg holds:
  - DW/AW constants;
  - csel codes SEL_NONE=000, SEL_L0=001, SEL_L1=011 (shared with the conv stage and the top-level arbiter);
  - state enum IDLE/READ/DRAIN/WRITE/FIN.
- One sub-module: maxpool_addr_gen.
  - Inputs: o and window index k.
  - Output: caddr_rd, purely combinational (shift/concatenate only, no multiplier).
- The FSM, running max and memory interface stay in maxpool_l1.

Test Plan:
- Ramp L0 (mem[a]=a), start pulse -> L1[o] = (2*oy+1)*64 + 2*ox + 1. Check L1[0]=65, L1[31]=127, L1[1023]=4095. done pulses exactly once, 6144 cycles after the first READ (RD_LAT=1).
- Max placed in each corner position in turn (other three = 0x00010, target = 0x12345) -> every L1 word = 0x12345, independent of position.
- All-negative window {0xFFFFB(-5), 0xFFFFD(-3), 0xFFFF8(-8), 0xFFFFF(-1)} -> output 0xFFFFF, not 0. Mixed window {0x7FFFF, 0x80000, 0, 1} -> output 0x7FFFF.
- Bus protocol monitor over a full frame -> never crd&cwr together; csel=001 on every crd cycle and 011 on every cwr cycle; exactly 4096 reads and 1024 writes; write addresses 0..1023 each written once.
- Second start pulse at output 100, plus start held high for 10 cycles -> no restart, no duplicate writes, single done pulse. reset driven low at output 500 -> all outputs return to reset values asynchronously; a fresh start then produces a full correct frame.
- RD_LAT=3 build with the ramp image -> same L1 contents; frame length 8192 cycles.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared definitions for the layer-1 max-pool stage: word sizes, memory-bus
// select codes (common with the conv stage and top-level arbiter) and FSM states.
package maxpool_pkg;

    localparam int unsigned DW = 20;
    localparam int unsigned AW = 12;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_L0   = 3'b001;
    localparam logic [2:0] SEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        FIN
    } state_e;

endpackage

// File: rtl/maxpool_addr_gen.sv
// L0 read address for window element k of pooled output o.
// Pure bit placement: row 2*oy+k[1], column 2*ox+k[0].
module maxpool_addr_gen #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned AW    = maxpool_pkg::AW,
    localparam int unsigned NW   = $clog2(IMG_W),
    localparam int unsigned OW   = 2 * (NW - 1)
) (
    input  logic [OW-1:0] o_i,
    input  logic [1:0]    k_i,
    output logic [AW-1:0] addr_o
);

    assign addr_o = AW'({o_i[OW-1:NW-1], k_i[1], o_i[NW-2:0], k_i[0]});

endmodule

// File: rtl/maxpool_l1.sv
// 2x2 stride-2 max pooling from L0 (64x64) into L1 (32x32) over the shared
// csel-multiplexed memory bus; one window per 5+RD_LAT cycles.
module maxpool_l1
    import maxpool_pkg::state_e, maxpool_pkg::IDLE, maxpool_pkg::READ,
           maxpool_pkg::DRAIN, maxpool_pkg::WRITE, maxpool_pkg::FIN,
           maxpool_pkg::SEL_NONE;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned DW     = maxpool_pkg::DW,
    parameter int unsigned AW     = maxpool_pkg::AW,
    parameter int unsigned RD_LAT = 1,
    parameter logic [2:0]  SEL_L0 = maxpool_pkg::SEL_L0,
    parameter logic [2:0]  SEL_L1 = maxpool_pkg::SEL_L1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int unsigned NW         = $clog2(IMG_W);
    localparam int unsigned OW         = 2 * (NW - 1);
    localparam logic [2:0]  LAST_RD    = 3'd3;
    localparam logic [2:0]  LAST_DRAIN = 3'(3 + RD_LAT);
    localparam logic [2:0]  FIRST_SMP  = 3'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic [OW-1:0] o_q, o_d;
    logic [2:0]    cyc_q, cyc_d;
    logic [DW-1:0] max_q, max_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          crd_q, crd_d, cwr_q, cwr_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic [2:0]    csel_q, csel_d;

    logic [OW-1:0] ag_o;
    logic [1:0]    ag_k;
    logic [AW-1:0] ag_addr;
    logic [2:0]    smp_idx;
    logic          smp_en;

    // Address for the read presented in the next cycle.
    assign ag_o = (state_q == WRITE) ? o_q + 1'b1 : o_q;
    assign ag_k = (state_q == READ) ? cyc_q[1:0] + 2'd1 : 2'd0;

    maxpool_addr_gen #(
        .IMG_W (IMG_W),
        .AW    (AW)
    ) u_addr_gen (
        .o_i    (ag_o),
        .k_i    (ag_k),
        .addr_o (ag_addr)
    );

    // Read k returns RD_LAT edges after presentation, i.e. at the end of cycle k+RD_LAT-1.
    assign smp_idx = cyc_q - FIRST_SMP;
    assign smp_en  = ((state_q == READ) || (state_q == DRAIN)) && !smp_idx[2];

    always_comb begin
        state_d    = state_q;
        o_d        = o_q;
        cyc_d      = cyc_q + 3'd1;
        max_d      = max_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = SEL_NONE;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;

        if (smp_en && ((smp_idx == 3'd0) || ($signed(cdata_rd) > $signed(max_q)))) begin
            max_d = cdata_rd;
        end

        unique case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (start) begin
                    state_d    = READ;
                    busy_d     = 1'b1;
                    crd_d      = 1'b1;
                    csel_d     = SEL_L0;
                    caddr_rd_d = ag_addr;
                end
            end
            READ: begin
                csel_d = SEL_L0;
                if (cyc_q == LAST_RD) begin
                    state_d = DRAIN;
                end else begin
                    crd_d      = 1'b1;
                    caddr_rd_d = ag_addr;
                end
            end
            DRAIN: begin
                csel_d = SEL_L0;
                if (cyc_q == LAST_DRAIN) begin
                    state_d    = WRITE;
                    cwr_d      = 1'b1;
                    csel_d     = SEL_L1;
                    caddr_wr_d = AW'(o_q);
                    cdata_wr_d = max_q;
                end
            end
            WRITE: begin
                cyc_d = '0;
                if (o_q == '1) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    o_d     = '0;
                end else begin
                    state_d    = READ;
                    o_d        = o_q + 1'b1;
                    crd_d      = 1'b1;
                    csel_d     = SEL_L0;
                    caddr_rd_d = ag_addr;
                end
            end
            FIN: begin
                cyc_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            o_q        <= '0;
            cyc_q      <= '0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= SEL_NONE;
        end else begin
            state_q    <= state_d;
            o_q        <= o_d;
            cyc_q      <= cyc_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;

endmodule
